ripple_count_ctrl: RTL

//  Synchronous sequencer for an external asynchronous WIDTH-bit ripple counter.

---
 rtl/ripple_count_ctrl_if.sv | 29 ++
 rtl/ripple_count_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_ctrl_if.sv
// Result port of the ripple counter sequencer.
// Purpose : carries one captured count from the sequencer to the readout
//           logic with a valid/ready handshake.
// Signals : res_valid    - result available (driven by master)
//           res_ready    - consumer accepts result (driven by slave)
//           res_count    - captured count, stable while res_valid=1
//           res_overflow - counter wrapped at least once during the measurement
interface ripple_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_count;
    logic             res_overflow;

    modport master (
        output res_valid,
        output res_count,
        output res_overflow,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_count,
        input  res_overflow,
        output res_ready
    );
endinterface

// File: rtl/ripple_count_ctrl.sv
// Sequencer for an external asynchronous ripple counter.
// Purpose : holds the counter in reset while idle; on start releases reset,
//           opens the event gate for a programmable number of clk cycles,
//           waits for the ripple to settle, then captures a stable count
//           through a 2-FF synchronizer and offers it on the result port.
// Ports   : clk      - system clock, rising edge
//           reset    - asynchronous, active-high
//           start    - request a measurement (accepted only when idle)
//           window   - gate length in clk cycles, latched on accepted start
//           ctr_rst  - registered, async reset of the ripple counter
//           ctr_gate - registered, enables the event clock into the counter
//           ctr_q    - ripple counter outputs, asynchronous to clk
//           busy     - high in any state other than IDLE
//           res      - result port (valid/ready, count, overflow)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | counter held in reset, waiting for start
// RELEASE | counter reset released, recovery time before the gate opens
// GATE    | event gate open for win_r cycles
// SETTLE  | gate closed, letting the ripple chain settle
// CAPTURE | sampling synchronized count until two consecutive samples agree
// HOLD    | result offered, waiting for res_ready
module ripple_count_ctrl #(
    parameter int WIDTH         = 4,
    parameter int WINDOW_W      = 16,
    parameter int REL_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WINDOW_W-1:0] window,
    output logic                ctr_rst,
    output logic                ctr_gate,
    input  logic [WIDTH-1:0]    ctr_q,
    output logic                busy,
    ripple_count_ctrl_if.master res
);

    // Shared down-counter must hold the window as well as both fixed delays.
    localparam int CNT_W = (WINDOW_W > 16) ? WINDOW_W : 16;

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        GATE,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WINDOW_W-1:0] win_q, win_d;
    logic                accept;
    logic                capture_done;

    logic [WIDTH-1:0]    sync1_q, sync2_q;
    logic [WIDTH-1:0]    samp_cur_q, samp_prev_q;
    logic [1:0]          samp_num_q;
    logic                msb_prev_q;
    logic                ovf_q;
    logic [WIDTH-1:0]    count_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        win_d        = win_q;
        accept       = 1'b0;
        capture_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    win_d   = window;
                    cnt_d   = CNT_W'(REL_CYCLES - 1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (cnt_q == '0) begin
                    if (win_q == '0) begin
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end else begin
                        cnt_d   = CNT_W'(win_q) - CNT_W'(1);
                        state_d = GATE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                // Two samples must be in hand before they can be compared.
                if (samp_num_q == 2'd2 && samp_cur_q == samp_prev_q) begin
                    capture_done = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (res.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= '0;
            ctr_rst     <= 1'b1;
            ctr_gate    <= 1'b0;
            busy        <= 1'b0;
            res.res_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            // Outputs are decoded from the next state so they change together with it.
            ctr_rst     <= (state_d == IDLE);
            ctr_gate    <= (state_d == GATE);
            busy        <= (state_d != IDLE);
            res.res_valid <= (state_d == HOLD);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            samp_cur_q  <= '0;
            samp_prev_q <= '0;
            samp_num_q  <= '0;
            msb_prev_q  <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            sync1_q    <= ctr_q;
            sync2_q    <= sync1_q;
            msb_prev_q <= sync2_q[WIDTH-1];

            if (state_q == CAPTURE) begin
                samp_cur_q  <= sync2_q;
                samp_prev_q <= samp_cur_q;
                if (samp_num_q != 2'd2) begin
                    samp_num_q <= samp_num_q + 2'd1;
                end
            end else begin
                samp_num_q <= '0;
            end

            // A falling MSB while counting means the counter wrapped.
            if (accept) begin
                ovf_q <= 1'b0;
            end else if ((state_q == GATE || state_q == SETTLE) &&
                         msb_prev_q && !sync2_q[WIDTH-1]) begin
                ovf_q <= 1'b1;
            end

            if (capture_done) begin
                count_q <= samp_cur_q;
            end
        end
    end

    assign res.res_count    = count_q;
    assign res.res_overflow = ovf_q;

endmodule
